multi_dataflow_fsm: RTL
=======================

# multi_dataflow_fsm

Job sequencer for the multi_dataflow HWPE. It sits between the control slave / register file and the streamer and engine. It snapshots the job configuration on start, then runs NB_ITER tiles. For each tile it programs the inStream0 source and the outStream0 sink with tile-advanced base addresses, fires the streamers and the engine, and waits for completion. It reports job completion back to the control slave.

## Interface
- ITER_W, 16: width of the tile iteration counter and nb_iter.
- ADDR_W, 32: TCDM byte-address width.
- clk_i  in  1  clock
- rst_ni  in  1  synchronous active-low reset
- clear_i  in  1  synchronous soft clear; same effect as reset
- start_i  in  1  job start pulse from control slave
- nb_iter_i  in  ITER_W  number of tiles (REG_NB_ITER)
- in_base_i / out_base_i  in  ADDR_W  tile-0 base addresses (REG_INSTREAM0_ADDR / REG_OUTSTREAM0_ADDR)
- tile_stride_i  in  ADDR_W  byte offset added per tile to both bases
- ctrl_fsm_i  in  ctrl_fsm_t  stream geometry plus cnt_limit_outStream0
- ctrl_streamer_o  out  ctrl_streamer_t  source/sink request and address-generator control
- flags_streamer_i  in  flags_streamer_t  ready_start / done per stream
- ctrl_engine_o  out  ctrl_engine_t  clear/enable/start/cnt_limit
- flags_engine_i  in  flags_engine_t  ready/done
- busy_o  out  1  high from the cycle after accepted start until done_o inclusive
- done_o  out  1  one-cycle job-complete pulse
- iter_o  out  ITER_W  index of the current tile

## Operation
- States: IDLE, ARM, COMPUTE, UPDATE, TERMINATE.
- IDLE, start_i=1: latch nb_iter_i, in_base_i, out_base_i, tile_stride_i and ctrl_fsm_i into snapshot registers, and clear iter.
  - nb_iter_i≠0 → ARM.
  - nb_iter_i=0 → TERMINATE directly. No streamer or engine start is issued.
- ARM: wait for all three of inStream0 ready_start, outStream0 ready_start and engine ready. In the cycle all three are high:
  - pulse both req_start signals and ctrl_engine_o.start for exactly that one cycle;
  - move to COMPUTE.
- COMPUTE: two sticky flags record outStream0_sink_flags.done and flags_engine_i.done. These may arrive in any order or in the same cycle. When both are recorded → UPDATE, and clear both flags.
- UPDATE:
  - iter = nb_iter−1 → TERMINATE.
  - Otherwise: iter+1, in_addr += stride, out_addr += stride → ARM.
- TERMINATE: done_o=1 for one cycle → IDLE.
- Addressgen fields (trans_size, line/feat stride/length, feat_roll, loop_outer, realign_type, step) are driven from the snapshot. base_addr is driven from the running address accumulators.
- Address arithmetic is modulo 2^ADDR_W; wrap is silent. iter never wraps because the nb_iter−1 compare terminates first.
- ctrl_engine_o:
  - enable=1 in every state except IDLE;
  - clear=clear_i|~rst_ni;
  - cnt_limit_outStream0 comes from the snapshot.
- start_i outside IDLE is ignored. Register-file changes during a job have no effect until the next start.
- inStream0 done is not waited on. The output sink completion implies the input stream has been consumed.

## Timing
- Reset/clear: state=IDLE, iter=0, accumulators=0, snapshot=0, sticky flags=0. All outputs read 0, except that ctrl_engine_o.clear reflects reset/clear.
- Reset or clear mid-job: IDLE on the next edge, with no done_o pulse.
- start_i at cycle t:
  - busy_o=1 from t+1;
  - earliest stream/engine start pulse at t+1, when ARM sees all ready;
  - nb_iter=0 gives done_o at t+1.
- Per-tile overhead: 1 ARM cycle (minimum) + 1 UPDATE cycle beyond the compute time.
- Both completion dones arriving in cycle c → UPDATE at c+1. If the tile is the last: TERMINATE at c+2, done_o high in c+2.
- busy_o falls in the cycle after done_o.
- start_i in the same cycle as done_o is ignored, because the state is TERMINATE, not IDLE.

## Structure
- multi_dataflow_package:
  - add fsm_state_e (5 states, 3-bit enum);
  - add ITER_W;
  - add nb_iter and tile_stride fields to ctrl_fsm_t;
  - keep ctrl_streamer_t, flags_streamer_t, ctrl_engine_t, flags_engine_t and ctrl_fsm_t there.
- One sub-module: multi_dataflow_tile_ctr. It holds the iteration counter plus the two address accumulators, with load (IDLE start), advance (UPDATE) and last_o (iter=nb_iter−1) controls.

## Test plan
- nb_iter=1, in_base=0x100, out_base=0x200, all readies held high → one req_start pulse per stream, base_addr 0x100/0x200; engine done 5 cycles before sink done → done_o exactly 2 cycles after sink done.
- nb_iter=3, stride=0x40 → base_addr sequence 0x100/0x140/0x180 (input), iter_o 0,1,2; exactly 3 start pulses, then one done_o.
- nb_iter=0 → done_o at start+1, no req_start or engine start ever asserted, busy_o high for 1 cycle.
- Sink ready_start held low 10 cycles in ARM → no start pulses until it rises; pulses are single-cycle even if readies stay high.
- rst_ni low mid-COMPUTE of tile 1 of 4 → IDLE, no done_o. Then start_i with nb_iter=2 → clean restart from iter 0 with the new config.
- start_i re-pulsed during COMPUTE plus nb_iter_i changed → ignored; the job completes with the original count, verified by the start pulse count.

Source files
------------

// File: rtl/multi_dataflow_fsm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : multi_dataflow_package
// Description : Shared types for the multi_dataflow job sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package multi_dataflow_package;

    localparam int c_ITER_W = 16;
    localparam int c_ADDR_W = 32;
    localparam int c_CNT_W  = 32;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ARM       = 3'd1,
        COMPUTE   = 3'd2,
        UPDATE    = 3'd3,
        TERMINATE = 3'd4
    } fsm_state_e;

    typedef struct packed {
        logic [31:0] trans_size;
        logic [15:0] line_stride, line_length, feat_stride, feat_length, feat_roll;
        logic        loop_outer;
        logic        realign_type;
        logic [15:0] step;
    } stream_geom_t;

    typedef struct packed {
        logic [c_ADDR_W-1:0] base_addr;
        logic [31:0]         trans_size;
        logic [15:0]         line_stride, line_length, feat_stride, feat_length, feat_roll;
        logic                loop_outer;
        logic                realign_type;
        logic [15:0]         step;
    } addressgen_ctrl_t;

    typedef struct packed {
        stream_geom_t        in_geom;
        stream_geom_t        out_geom;
        logic [c_CNT_W-1:0]  cnt_limit_outStream0;
        logic [c_ITER_W-1:0] nb_iter;
        logic [c_ADDR_W-1:0] tile_stride;
    } ctrl_fsm_t;

    typedef struct packed {
        logic             req_start;
        addressgen_ctrl_t addressgen_ctrl;
    } stream_ctrl_t;

    typedef struct packed {
        stream_ctrl_t inStream0_source_ctrl;
        stream_ctrl_t outStream0_sink_ctrl;
    } ctrl_streamer_t;

    typedef struct packed {
        logic ready_start;
        logic done;
    } stream_flags_t;

    typedef struct packed {
        stream_flags_t inStream0_source_flags;
        stream_flags_t outStream0_sink_flags;
    } flags_streamer_t;

    typedef struct packed {
        logic               clear;
        logic               enable;
        logic               start;
        logic [c_CNT_W-1:0] cnt_limit_outStream0;
    } ctrl_engine_t;

    typedef struct packed {
        logic ready;
        logic done;
    } flags_engine_t;

    function automatic addressgen_ctrl_t make_addressgen(input logic [c_ADDR_W-1:0] base,
                                                         input stream_geom_t geom);
        make_addressgen = '{base_addr:    base,
                            trans_size:   geom.trans_size,
                            line_stride:  geom.line_stride,
                            line_length:  geom.line_length,
                            feat_stride:  geom.feat_stride,
                            feat_length:  geom.feat_length,
                            feat_roll:    geom.feat_roll,
                            loop_outer:   geom.loop_outer,
                            realign_type: geom.realign_type,
                            step:         geom.step};
    endfunction

endpackage
`default_nettype wire

// File: rtl/multi_dataflow_fsm_if.sv
`default_nettype none
// ============================================================================
// Module      : multi_dataflow_fsm_if
// Description : Sequencer <-> streamer/engine control and status bundle.
// Revision    : 1.0 - initial release
// ============================================================================
interface multi_dataflow_fsm_if;
    import multi_dataflow_package::*;

    ctrl_streamer_t  ctrl_streamer;
    flags_streamer_t flags_streamer;
    ctrl_engine_t    ctrl_engine;
    flags_engine_t   flags_engine;

    modport master (
        output ctrl_streamer, ctrl_engine,
        input  flags_streamer, flags_engine
    );

    modport slave (
        input  ctrl_streamer, ctrl_engine,
        output flags_streamer, flags_engine
    );
endinterface
`default_nettype wire

// File: rtl/multi_dataflow_fsm_tile_ctr.sv
`default_nettype none
// ============================================================================
// Module      : multi_dataflow_tile_ctr
// Description : Tile index counter and per-tile base address accumulators.
// Revision    : 1.0 - initial release
// ============================================================================
module multi_dataflow_tile_ctr #(
    parameter int ITER_W = 16,
    parameter int ADDR_W = 32
) (
    input  wire logic              clk_i,
    input  wire logic              rst_ni,
    input  wire logic              clear_i,
    input  wire logic              load_i,
    input  wire logic              advance_i,
    input  wire logic [ITER_W-1:0] nb_iter_i,
    input  wire logic [ADDR_W-1:0] in_base_i,
    input  wire logic [ADDR_W-1:0] out_base_i,
    input  wire logic [ADDR_W-1:0] stride_i,
    output logic      [ITER_W-1:0] iter_o,
    output logic      [ADDR_W-1:0] in_addr_o,
    output logic      [ADDR_W-1:0] out_addr_o,
    output logic                   last_o
);

    logic [ITER_W-1:0] r_iter;
    logic [ADDR_W-1:0] r_in_addr;
    logic [ADDR_W-1:0] r_out_addr;

    // Address sums wrap modulo 2^ADDR_W by construction.
    always_ff @(posedge clk_i) begin
        if (!rst_ni || clear_i) begin
            r_iter     <= '0;
            r_in_addr  <= '0;
            r_out_addr <= '0;
        end else if (load_i) begin
            r_iter     <= '0;
            r_in_addr  <= in_base_i;
            r_out_addr <= out_base_i;
        end else if (advance_i) begin
            r_iter     <= r_iter + ITER_W'(1);
            r_in_addr  <= r_in_addr + stride_i;
            r_out_addr <= r_out_addr + stride_i;
        end
    end

    assign iter_o     = r_iter;
    assign in_addr_o  = r_in_addr;
    assign out_addr_o = r_out_addr;
    assign last_o     = (r_iter == nb_iter_i - ITER_W'(1));

endmodule
`default_nettype wire

// File: rtl/multi_dataflow_fsm.sv
`default_nettype none
// ============================================================================
// Module      : multi_dataflow_fsm
// Description : Job sequencer running NB_ITER tiles through streamer + engine.
// Revision    : 1.0 - initial release
// ============================================================================
module multi_dataflow_fsm
    import multi_dataflow_package::*;
#(
    parameter int ITER_W = c_ITER_W,
    parameter int ADDR_W = c_ADDR_W
) (
    input  wire logic              clk_i,
    input  wire logic              rst_ni,
    input  wire logic              clear_i,
    input  wire logic              start_i,
    input  wire logic [ITER_W-1:0] nb_iter_i,
    input  wire logic [ADDR_W-1:0] in_base_i,
    input  wire logic [ADDR_W-1:0] out_base_i,
    input  wire logic [ADDR_W-1:0] tile_stride_i,
    input  wire ctrl_fsm_t         ctrl_fsm_i,
    multi_dataflow_fsm_if.master   bus,
    output logic                   busy_o,
    output logic                   done_o,
    output logic      [ITER_W-1:0] iter_o
);

    fsm_state_e        r_state;
    fsm_state_e        w_state_nxt;
    ctrl_fsm_t         r_cfg;
    logic              r_sink_done;
    logic              r_eng_done;
    logic              w_sink_done;
    logic              w_eng_done;
    logic              w_all_ready;
    logic              w_load;
    logic              w_advance;
    logic              w_fire;
    logic              w_last;
    logic [ADDR_W-1:0] w_in_addr;
    logic [ADDR_W-1:0] w_out_addr;

    assign w_all_ready = bus.flags_streamer.inStream0_source_flags.ready_start &
                         bus.flags_streamer.outStream0_sink_flags.ready_start &
                         bus.flags_engine.ready;
    assign w_sink_done = r_sink_done | bus.flags_streamer.outStream0_sink_flags.done;
    assign w_eng_done  = r_eng_done  | bus.flags_engine.done;

    always_ff @(posedge clk_i) begin
        if (!rst_ni || clear_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_advance   = 1'b0;
        w_fire      = 1'b0;
        case (r_state)
            IDLE: begin
                if (start_i) begin
                    w_load      = 1'b1;
                    w_state_nxt = (nb_iter_i != '0) ? ARM : TERMINATE;
                end
            end
            ARM: begin
                if (w_all_ready) begin
                    w_fire      = 1'b1;
                    w_state_nxt = COMPUTE;
                end
            end
            COMPUTE: begin
                if (w_sink_done && w_eng_done) w_state_nxt = UPDATE;
            end
            UPDATE: begin
                if (w_last) begin
                    w_state_nxt = TERMINATE;
                end else begin
                    w_advance   = 1'b1;
                    w_state_nxt = ARM;
                end
            end
            TERMINATE: w_state_nxt = IDLE;
            default:   w_state_nxt = IDLE;
        endcase
    end

    // Job configuration is frozen at start so register writes mid-job are inert.
    always_ff @(posedge clk_i) begin
        if (!rst_ni || clear_i) begin
            r_cfg <= '0;
        end else if (w_load) begin
            r_cfg             <= ctrl_fsm_i;
            r_cfg.nb_iter     <= nb_iter_i;
            r_cfg.tile_stride <= tile_stride_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni || clear_i) begin
            r_sink_done <= 1'b0;
            r_eng_done  <= 1'b0;
        end else if (r_state == COMPUTE) begin
            if (w_sink_done && w_eng_done) begin
                r_sink_done <= 1'b0;
                r_eng_done  <= 1'b0;
            end else begin
                r_sink_done <= w_sink_done;
                r_eng_done  <= w_eng_done;
            end
        end
    end

    multi_dataflow_tile_ctr #(
        .ITER_W (ITER_W),
        .ADDR_W (ADDR_W)
    ) u_tile_ctr (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .clear_i    (clear_i),
        .load_i     (w_load),
        .advance_i  (w_advance),
        .nb_iter_i  (r_cfg.nb_iter),
        .in_base_i  (in_base_i),
        .out_base_i (out_base_i),
        .stride_i   (r_cfg.tile_stride),
        .iter_o     (iter_o),
        .in_addr_o  (w_in_addr),
        .out_addr_o (w_out_addr),
        .last_o     (w_last)
    );

    assign bus.ctrl_streamer = '{
        inStream0_source_ctrl: '{req_start:       w_fire,
                                 addressgen_ctrl: make_addressgen(w_in_addr, r_cfg.in_geom)},
        outStream0_sink_ctrl:  '{req_start:       w_fire,
                                 addressgen_ctrl: make_addressgen(w_out_addr, r_cfg.out_geom)}
    };

    assign bus.ctrl_engine = '{
        clear:                clear_i | ~rst_ni,
        enable:               (r_state != IDLE),
        start:                w_fire,
        cnt_limit_outStream0: r_cfg.cnt_limit_outStream0
    };

    assign busy_o = (r_state != IDLE);
    assign done_o = (r_state == TERMINATE);

endmodule
`default_nettype wire
